// File: rtl/spi_wrapper.sv
// spi_wrapper: SPI slave front-end plus a 256 x 8 single-port RAM.
//
// A frame starts when SS_n falls. The first MOSI bit after the select cycle
// is the command bit (0 = write family, 1 = read family). Ten more bits are
// then shifted MSB-first into din, and din is handed to the RAM as a
// one-cycle rx_valid command. A read-data command returns the addressed
// byte MSB-first on MISO.
//
// Ports
//   clk   in  system clock, rising-edge
//   rst_n in  synchronous reset, active HIGH (legacy name)
//   SS_n  in  slave select, active low; high aborts or ends a frame
//   MOSI  in  serial data in, sampled on rising clk
//   MISO  out serial data out, 0 whenever no byte is being shifted
//
// Handshake between slave and RAM: rx_valid is a single-cycle strobe
// that qualifies din; tx_valid is a single-cycle strobe that qualifies
// dout. Neither side can stall the other, so there is no ready signal.

module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_din,
  input  logic       i_rx_valid,
  output logic [7:0] o_dout,
  output logic       o_tx_valid
);

  logic [7:0]           SP_RAM [0:MEM_DEPTH-1];
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_rx_valid && (i_din[9:8] == 2'b01)) begin
      SP_RAM[r_wr_addr] <= i_din[7:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      o_dout     <= '0;
      o_tx_valid <= 1'b0;
    end else begin
      o_tx_valid <= 1'b0;
      if (i_rx_valid) begin
        case (i_din[9:8])
          2'b00: r_wr_addr <= i_din[7:0];
          2'b10: r_rd_addr <= i_din[7:0];
          2'b11: begin
            o_dout     <= SP_RAM[r_rd_addr];
            o_tx_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

module spi_wrapper #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_bit_cnt;
  logic [9:0] r_din;
  logic       r_rx_valid;
  logic       r_rd_addr_received;
  logic       r_shifting;
  logic [2:0] r_tx_idx;
  logic [7:0] w_dout;
  logic       w_tx_valid;
  logic       w_data_state;
  logic       w_capture;
  logic       w_last_bit;

  always_ff @(posedge clk) begin
    if (rst_n) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!SS_n) w_next_state = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)                    w_next_state = IDLE;
        else if (!MOSI)              w_next_state = WRITE;
        else if (r_rd_addr_received) w_next_state = READ_DATA;
        else                         w_next_state = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: if (SS_n) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign w_data_state = (r_state == WRITE) || (r_state == READ_ADD) ||
                        (r_state == READ_DATA);
  // Once ten bits are in, the counter parks at 10 and further bits are
  // ignored until the master deselects.
  assign w_capture    = w_data_state && !SS_n && (r_bit_cnt != 4'd10);
  assign w_last_bit   = w_capture && (r_bit_cnt == 4'd9);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_bit_cnt          <= '0;
      r_din              <= '0;
      r_rx_valid         <= 1'b0;
      r_rd_addr_received <= 1'b0;
      r_shifting         <= 1'b0;
      r_tx_idx           <= '0;
    end else begin
      r_rx_valid <= w_last_bit;

      if (w_capture) begin
        r_din     <= {r_din[8:0], MOSI};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end else if (!(w_data_state && !SS_n)) begin
        r_bit_cnt <= '0;
      end

      if ((r_state == CHK_CMD) && !SS_n && MOSI && r_rd_addr_received)
        r_rd_addr_received <= 1'b0;
      else if ((r_state == READ_ADD) && w_last_bit)
        r_rd_addr_received <= 1'b1;

      // dout[7] is shown during the tx_valid cycle itself; the index
      // register takes over from dout[6] onwards.
      if ((r_state != READ_DATA) || SS_n) begin
        r_shifting <= 1'b0;
      end else if (w_tx_valid) begin
        r_shifting <= 1'b1;
        r_tx_idx   <= 3'd6;
      end else if (r_shifting) begin
        if (r_tx_idx == 3'd0) r_shifting <= 1'b0;
        else                  r_tx_idx   <= r_tx_idx - 3'd1;
      end
    end
  end

  always_comb begin
    MISO = 1'b0;
    if (r_state == READ_DATA) begin
      if (w_tx_valid)      MISO = w_dout[7];
      else if (r_shifting) MISO = w_dout[r_tx_idx];
    end
  end

  spi_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) SRAM (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_din      (r_din),
    .i_rx_valid (r_rx_valid),
    .o_dout     (w_dout),
    .o_tx_valid (w_tx_valid)
  );

endmodule

// File: tb/tb_spi_wrapper.sv
// Bench for spi_wrapper: drives whole SPI frames and compares the byte seen
// on MISO with a frame-level model of the command rules.

module tb_spi_wrapper;

  logic clk = 1'b0;
  logic rst_n;
  logic SS_n;
  logic MOSI;
  logic MISO;

  int n_checks = 0;
  int n_errors = 0;

  spi_wrapper dut (
    .clk   (clk),
    .rst_n (rst_n),
    .SS_n  (SS_n),
    .MOSI  (MOSI),
    .MISO  (MISO)
  );

  always #5 clk = ~clk;

  // ---------------- frame-level reference model ----------------
  logic [7:0] m_mem [256];
  logic [7:0] m_wr;
  logic [7:0] m_rd;
  bit         m_flag;

  function automatic void model_reset();
    m_wr   = 8'h00;
    m_rd   = 8'h00;
    m_flag = 1'b0;
  endfunction

  // Returns the byte a master should collect on MISO for one full frame.
  function automatic logic [7:0] model_frame(input logic [10:0] f);
    bit         rd_mode = 1'b0;
    logic [7:0] res     = 8'h00;
    if (f[10]) begin
      if (m_flag) begin rd_mode = 1'b1; m_flag = 1'b0; end
      else        m_flag = 1'b1;
    end
    case (f[9:8])
      2'b00: m_wr = f[7:0];
      2'b01: m_mem[m_wr] = f[7:0];
      2'b10: m_rd = f[7:0];
      default: if (rd_mode) res = m_mem[m_rd];
    endcase
    return res;
  endfunction

  function automatic logic [10:0] mk(input logic cmd, input logic [1:0] op,
                                     input logic [7:0] b);
    return {cmd, op, b};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check8(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // One full frame: select cycle, command bit, ten data bits, then eight
  // MISO samples taken on falling edges after E12..E19, then one deselect.
  task automatic do_frame(input logic [10:0] f, output logic [7:0] got);
    SS_n = 1'b0; MOSI = 1'b0;
    @(negedge clk);
    for (int i = 10; i >= 0; i--) begin
      MOSI = f[i];
      @(negedge clk);
    end
    MOSI = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      @(negedge clk);
      got[k] = MISO;
    end
    SS_n = 1'b1;
    @(negedge clk);
    check8("idle_miso", {7'd0, MISO}, 8'h00);
  endtask

  task automatic run_frame(input string name, input logic [10:0] f);
    logic [7:0] exp;
    logic [7:0] got;
    exp = model_frame(f);
    do_frame(f, got);
    check8(name, got, exp);
  endtask

  typedef struct {
    logic [10:0] frame;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [7:0]  a, d, got, v;
    logic [10:0] f;
    logic        exp_bit;

    // clock/reset
    rst_n = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
    repeat (2) @(negedge clk);
    check8("reset_miso", {7'd0, MISO}, 8'h00);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);

    // preload all memory with random bytes, known word at 0x10
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom_range(0, 255));
      m_mem[i] = v;
      dut.SRAM.SP_RAM[i] = v;
    end
    m_mem[16] = 8'hA5;
    dut.SRAM.SP_RAM[16] = 8'hA5;

    // table: preload read, then write 0x5A/0xC3 and read it back
    vecs[0] = '{mk(1'b1, 2'b10, 8'h10), 8'h00};
    vecs[1] = '{mk(1'b1, 2'b11, 8'h00), 8'hA5};
    vecs[2] = '{mk(1'b0, 2'b00, 8'h5A), 8'h00};
    vecs[3] = '{mk(1'b0, 2'b01, 8'hC3), 8'h00};
    vecs[4] = '{mk(1'b1, 2'b10, 8'h5A), 8'h00};
    vecs[5] = '{mk(1'b1, 2'b11, 8'hFF), 8'hC3};
    for (int i = 0; i < 6; i++) begin
      v = model_frame(vecs[i].frame);
      do_frame(vecs[i].frame, got);
      check8($sformatf("vec%0d", i), got, vecs[i].exp);
    end
    check8("ram_5a", dut.SRAM.SP_RAM[8'h5A], 8'hC3);

    // random round trips
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      run_frame("rnd_wa", mk(1'b0, 2'b00, a));
      run_frame("rnd_wd", mk(1'b0, 2'b01, d));
      run_frame("rnd_ra", mk(1'b1, 2'b10, a));
      run_frame($sformatf("rnd_rd%0d", i), mk(1'b1, 2'b11, 8'h00));
    end

    // aborted write-data frame after 5 bits
    run_frame("ab_wa", mk(1'b0, 2'b00, 8'h33));
    run_frame("ab_wd", mk(1'b0, 2'b01, 8'h5C));
    f = mk(1'b0, 2'b01, 8'hE7);
    SS_n = 1'b0; MOSI = 1'b0;
    @(negedge clk);
    for (int i = 10; i >= 6; i--) begin
      MOSI = f[i];
      @(negedge clk);
    end
    SS_n = 1'b1; MOSI = 1'b0;
    repeat (3) @(negedge clk);
    check8("ab_ram", dut.SRAM.SP_RAM[8'h33], 8'h5C);
    run_frame("ab_ra", mk(1'b1, 2'b10, 8'h33));
    run_frame("ab_rd", mk(1'b1, 2'b11, 8'h00));
    run_frame("ab_wd2", f);
    run_frame("ab_ra2", mk(1'b1, 2'b10, 8'h33));
    run_frame("ab_rd2", mk(1'b1, 2'b11, 8'h00));

    // back-to-back read-address frames
    run_frame("rr_ra1", mk(1'b1, 2'b10, 8'h10));
    run_frame("rr_ra2", mk(1'b1, 2'b10, 8'h5A));
    run_frame("rr_rd1", mk(1'b1, 2'b11, 8'h00));
    run_frame("rr_rd2", mk(1'b1, 2'b11, 8'h00));

    // reset in the middle of a read-data frame while MISO is shifting
    run_frame("rst_ra", mk(1'b1, 2'b10, 8'h44));
    v = model_frame(mk(1'b1, 2'b11, 8'h00));
    exp_bit = v[5];
    f = mk(1'b1, 2'b11, 8'h00);
    SS_n = 1'b0; MOSI = 1'b0;
    @(negedge clk);
    for (int i = 10; i >= 0; i--) begin
      MOSI = f[i];
      @(negedge clk);
    end
    MOSI = 1'b0;
    repeat (3) @(negedge clk);
    check8("rst_pre_bit5", {7'd0, MISO}, {7'd0, exp_bit});
    rst_n = 1'b1;
    @(negedge clk);
    check8("rst_miso", {7'd0, MISO}, 8'h00);
    rst_n = 1'b0; SS_n = 1'b1;
    model_reset();
    @(negedge clk);
    run_frame("rst_ra2", mk(1'b1, 2'b10, 8'h33));
    run_frame("rst_rd2", mk(1'b1, 2'b11, 8'h00));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
